// File: rtl/sp_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sp_ram_arbiter
//  Description : Round-robin arbiter and zero-fill sequencer in front of a
//                single-port RAM wrapper. Shares one RAM port between
//                NUM_PORTS requesters over a req/gnt/rvalid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int INIT_ZERO  = 1
) (
    input  logic                                 clk,
    input  logic                                 rstn_i,

    // Requester side
    input  logic [NUM_PORTS-1:0]                 req_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 init_done_o,

    // Memory side
    output logic                                 mem_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NUM_WORDS = RAM_SIZE / 4;
    localparam int c_WCNT_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
    localparam int c_PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_BE_W      = DATA_WIDTH / 8;

    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(c_NUM_WORDS - 1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PORT = c_PTR_W'(NUM_PORTS - 1);
    localparam logic [c_PTR_W:0]    c_NPORTS_EXT = (c_PTR_W + 1)'(NUM_PORTS);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_ARB;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_WCNT_W-1:0]    r_wcnt;
    logic [c_PTR_W-1:0]     r_rr;
    logic [NUM_PORTS-1:0]   r_resp;
    logic                   r_init_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_found;
    logic [c_PTR_W-1:0]     w_sel;
    logic [c_PTR_W:0]       w_cand;
    logic [c_PTR_W-1:0]     w_cidx;
    logic [ADDR_WIDTH-1:0]  w_addr_sel;

    // Round-robin search: first requesting port starting at r_rr, wrapping
    // modulo NUM_PORTS (works for non-power-of-two port counts too).
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        w_cidx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = {1'b0, r_rr} + (c_PTR_W + 1)'(i);
            if (w_cand >= c_NPORTS_EXT) begin
                w_cand = w_cand - c_NPORTS_EXT;
            end
            w_cidx = w_cand[c_PTR_W-1:0];
            if (!w_found && req_i[w_cidx]) begin
                w_found = 1'b1;
                w_sel   = w_cidx;
            end
        end
    end

    assign w_addr_sel = addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];

    // Grant and memory-port mux; everything is forced to zero while reset is
    // low so the RAM sees no stray access during reset.
    always_comb begin
        gnt_o       = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (rstn_i) begin
            if (r_state == ST_INIT) begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = '1;
                mem_wdata_o = '0;
                mem_addr_o  = ADDR_WIDTH'({r_wcnt, 2'b00});
            end else if (w_found) begin
                gnt_o[w_sel] = 1'b1;
                mem_en_o     = 1'b1;
                mem_we_o     = we_i[w_sel];
                mem_be_o     = be_i[w_sel*c_BE_W +: c_BE_W];
                mem_wdata_o  = wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
                // Word-align: the RAM ignores the byte offset.
                mem_addr_o   = w_addr_sel & ~ADDR_WIDTH'(3);
            end
        end
    end

    // Control FSM: zero-fill counter, round-robin pointer and response pipe.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_state     <= c_RST_STATE;
            r_wcnt      <= '0;
            r_rr        <= '0;
            r_resp      <= '0;
            r_init_done <= (INIT_ZERO == 0);
        end else begin
            r_resp <= gnt_o;
            case (r_state)
                ST_INIT: begin
                    if (r_wcnt == c_LAST_WORD) begin
                        r_state     <= ST_ARB;
                        r_init_done <= 1'b1;
                        r_wcnt      <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_ARB: begin
                    // Pointer moves past the winner; holds when idle.
                    if (w_found) begin
                        r_rr <= (w_sel == c_LAST_PORT) ? '0 : w_sel + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_RST_STATE;
                end
            endcase
        end
    end

    // Response path: rvalid follows the grant by one cycle; data is shared
    // and only passed through when some port has a response in flight.
    always_comb begin
        rvalid_o    = rstn_i ? r_resp : '0;
        rdata_o     = (rstn_i && (|r_resp)) ? mem_rdata_i : '0;
        init_done_o = rstn_i & r_init_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_arbiter
//  Description : Self-checking bench for sp_ram_arbiter with a RAM model,
//                vector table, directed reset sequences and a randomized
//                phase checked against a behavioural reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int RS = 64;
    localparam int AW = 6;
    localparam int NP = 2;
    localparam int NW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [NP-1:0]       req_i, gnt, we_i, rvalid;
    logic [NP*AW-1:0]    addr_i;
    logic [NP*4-1:0]     be_i;
    logic [NP*32-1:0]    wdata_i;
    logic [31:0]         rdata, mem_wdata, ram_rd;
    logic                init_done, mem_en, mem_we;
    logic [AW-1:0]       mem_addr;
    logic [3:0]          mem_be;

    sp_ram_arbiter #(
        .RAM_SIZE  (RS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(32),
        .NUM_PORTS (NP),
        .INIT_ZERO (1)
    ) dut (
        .clk        (clk),
        .rstn_i     (rstn),
        .req_i      (req_i),
        .gnt_o      (gnt),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .init_done_o(init_done),
        .mem_en_o   (mem_en),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_be_o   (mem_be),
        .mem_rdata_i(ram_rd)
    );

    // Single-port RAM model: byte-enabled writes, registered read data.
    logic [31:0] ram [NW];
    logic        ram_seed;
    always @(posedge clk) begin
        if (ram_seed) begin
            for (int i = 0; i < NW; i++) ram[i] <= 32'hA5A50000 | i;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                ram_rd <= ram[mem_addr[5:2]];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] rq, input logic [NP-1:0] w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_i   = rq;
        we_i    = w;
        addr_i  = {a1, a0};
        be_i    = {b1, b0};
        wdata_i = {d1, d0};
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {47'h0, gnt, rvalid, init_done, mem_en, mem_we, mem_be, mem_addr}, 64'h0);
        chk({nm, "_data"}, {rdata, mem_wdata}, 64'h0);
    endtask

    // Checks NW zero-fill cycles, then the init_done rise in cycle NW.
    // Called at posedge+1 of post-reset cycle 0; returns at negedge of cycle NW.
    task automatic check_fill();
        for (int c = 0; c < NW; c++) begin
            @(negedge clk);
            chk($sformatf("fill_cycle%0d", c),
                {16'h0, mem_en, mem_we, mem_be, mem_wdata, mem_addr, init_done, gnt},
                {16'h0, 1'b1, 1'b1, 4'hF, 32'h0, AW'(c*4), 1'b0, 2'b00});
            step();
        end
        @(negedge clk);
        chk("init_done_rise", {63'h0, init_done}, 64'h1);
    endtask

    // Port 1 reads every word and expects zero.
    task automatic read_all_zero(input string nm);
        for (int w = 0; w < NW; w++) begin
            drive(2'b10, 2'b00, '0, AW'(w*4), 4'h0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("%s%0d_gnt", nm, w), {56'h0, gnt, mem_addr}, {56'h0, 2'b10, AW'(w*4)});
            step();
            drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("%s%0d_rsp", nm, w), {30'h0, rvalid, rdata}, {30'h0, 2'b10, 32'h0});
            step();
        end
    endtask

    // Vector table
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [5:0]  a0, a1;
        logic [3:0]  b0, b1;
        logic [31:0] d0, d1;
        logic [1:0]  eg;
        logic [5:0]  ea;
        logic        cr;
        logic [31:0] erd;
    } tv_t;

    function automatic tv_t mk(input logic [1:0] req, input logic [1:0] we,
                               input logic [5:0] a0, input logic [5:0] a1,
                               input logic [3:0] b0, input logic [3:0] b1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] eg, input logic [5:0] ea,
                               input logic cr, input logic [31:0] erd);
        tv_t t;
        t.req = req; t.we = we; t.a0 = a0; t.a1 = a1; t.b0 = b0; t.b1 = b1;
        t.d0 = d0; t.d1 = d1; t.eg = eg; t.ea = ea; t.cr = cr; t.erd = erd;
        return t;
    endfunction

    task automatic rsp_check(input tv_t t, input int idx);
        chk($sformatf("vec%0d_rvalid", idx), {62'h0, rvalid}, {62'h0, t.eg});
        if (t.cr) chk($sformatf("vec%0d_rdata", idx), {32'h0, rdata}, {32'h0, t.erd});
    endtask

    tv_t tv [13];

    // Reference model state for the random phase
    logic              pend [NP];
    logic [AW-1:0]     pa   [NP];
    logic              pw   [NP];
    logic [3:0]        pb   [NP];
    logic [31:0]       pd   [NP];
    logic [31:0]       em   [NW];
    int                m_rr, k, p, word;
    logic [NP-1:0]     e_rv, eg;
    logic [31:0]       e_rd;
    logic              e_rdchk;
    logic [45:0]       e_mem;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr starts at 0 when the table begins (left there by port-1 reads).
        tv[0]  = mk(2'b01, 2'b01, 6'h10, 6'h00, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, 6'h10, 1'b0, 32'h0);
        tv[1]  = mk(2'b01, 2'b00, 6'h10, 6'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 6'h10, 1'b1, 32'hDEADBEEF);
        tv[2]  = mk(2'b10, 2'b10, 6'h00, 6'h20, 4'h0, 4'h1, 32'h0, 32'h000000AA, 2'b10, 6'h20, 1'b0, 32'h0);
        tv[3]  = mk(2'b10, 2'b10, 6'h00, 6'h20, 4'h0, 4'h2, 32'h0, 32'h0000BB00, 2'b10, 6'h20, 1'b0, 32'h0);
        tv[4]  = mk(2'b10, 2'b00, 6'h00, 6'h20, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 6'h20, 1'b1, 32'h0000BBAA);
        tv[5]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 6'h00, 1'b1, 32'h0);
        for (int i = 6; i < 12; i++) begin
            if (i % 2 == 0)
                tv[i] = mk(2'b11, 2'b00, 6'h10, 6'h20, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 6'h10, 1'b1, 32'hDEADBEEF);
            else
                tv[i] = mk(2'b11, 2'b00, 6'h10, 6'h20, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 6'h20, 1'b1, 32'h0000BBAA);
        end
        tv[12] = mk(2'b01, 2'b00, 6'h13, 6'h00, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 6'h10, 1'b1, 32'hDEADBEEF);

        // Reset, with the RAM seeded with non-zero garbage
        rstn = 1'b0;
        ram_seed = 1'b1;
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        step();
        ram_seed = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_state");
        step();

        // Zero-fill with a port-1 read held from cycle 0
        rstn = 1'b1;
        drive(2'b10, 2'b00, '0, 6'h3C, 4'h0, 4'h0, 32'h0, 32'h0);
        check_fill();
        chk("held_grant", {55'h0, gnt, mem_addr, mem_we}, {55'h0, 2'b10, 6'h3C, 1'b0});
        step();
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("held_rsp", {30'h0, rvalid, rdata}, {30'h0, 2'b10, 32'h0});
        step();
        read_all_zero("zero_word");

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].req, tv[i].we, tv[i].a0, tv[i].a1, tv[i].b0, tv[i].b1, tv[i].d0, tv[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), {55'h0, gnt, mem_en, mem_addr},
                {55'h0, tv[i].eg, |tv[i].eg, tv[i].ea});
            if (i > 0) rsp_check(tv[i-1], i-1);
            step();
        end
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rsp_check(tv[12], 12);
        step();

        // Randomized phase against the reference model
        for (int i = 0; i < NW; i++) em[i] = 32'h0;
        em[4] = 32'hDEADBEEF;
        em[8] = 32'h0000BBAA;
        m_rr = 1;
        e_rv = '0;
        e_rd = 32'h0;
        e_rdchk = 1'b1;
        for (int i = 0; i < NP; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pw[i] = 1'b0; pb[i] = 4'h0; pd[i] = 32'h0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int q = 0; q < NP; q++) begin
                if (!pend[q] && $urandom_range(0, 99) < 65) begin
                    pend[q] = 1'b1;
                    pa[q]   = AW'($urandom_range(0, 63));
                    pw[q]   = 1'($urandom_range(0, 1));
                    pb[q]   = 4'($urandom_range(0, 15));
                    pd[q]   = $urandom;
                end
            end
            drive({pend[1], pend[0]}, {pw[1], pw[0]}, pa[0], pa[1], pb[0], pb[1], pd[0], pd[1]);
            @(negedge clk);
            k = -1;
            for (int off = 0; off < NP; off++) begin
                p = (m_rr + off) % NP;
                if (k < 0 && pend[p]) k = p;
            end
            if (k >= 0) begin
                eg = NP'(1) << k;
                e_mem = {eg, 1'b1, pw[k], pb[k], {pa[k][5:2], 2'b00}, pd[k]};
            end else begin
                eg = '0;
                e_mem = '0;
            end
            chk($sformatf("rand%0d_mem", n), {18'h0, gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                {18'h0, e_mem});
            chk($sformatf("rand%0d_rvalid", n), {62'h0, rvalid}, {62'h0, e_rv});
            if (e_rdchk) chk($sformatf("rand%0d_rdata", n), {32'h0, rdata}, {32'h0, e_rd});
            if (k >= 0) begin
                word = int'(pa[k][5:2]);
                if (pw[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (pb[k][b]) em[word][8*b +: 8] = pd[k][8*b +: 8];
                    e_rdchk = 1'b0;
                end else begin
                    e_rd = em[word];
                    e_rdchk = 1'b1;
                end
                e_rv = eg;
                pend[k] = 1'b0;
                m_rr = (k + 1) % NP;
            end else begin
                e_rv = '0;
                e_rd = 32'h0;
                e_rdchk = 1'b1;
            end
            step();
        end
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rand_last_rvalid", {62'h0, rvalid}, {62'h0, e_rv});
        if (e_rdchk) chk("rand_last_rdata", {32'h0, rdata}, {32'h0, e_rd});
        step();

        // Reset in the cycle after a grant: the response must be dropped
        drive(2'b01, 2'b00, 6'h10, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pre_rst_gnt", {62'h0, gnt}, {62'h0, 2'b01});
        step();
        rstn = 1'b0;
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk_all_zero("rst_drop");
        step();

        // Reset during the fill at wcnt=7, held low for two cycles
        rstn = 1'b1;
        for (int c = 0; c < 7; c++) step();
        @(negedge clk);
        chk("pre_rst_wcnt7", {58'h0, mem_addr}, {58'h0, 6'd28});
        step();
        rstn = 1'b0;
        step();
        @(negedge clk);
        chk_all_zero("rst_mid_init");
        step();
        rstn = 1'b1;
        drive(2'b11, 2'b00, 6'h00, 6'h04, 4'h0, 4'h0, 32'h0, 32'h0);
        check_fill();
        // rr was left at 1 before reset; after reset port 0 wins first
        chk("refill_first_gnt", {62'h0, gnt}, {62'h0, 2'b01});
        step();
        drive(2'b10, 2'b00, 6'h00, 6'h04, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("refill_second_gnt", {62'h0, gnt}, {62'h0, 2'b10});
        chk("refill_rsp0", {30'h0, rvalid, rdata}, {30'h0, 2'b01, 32'h0});
        step();
        drive('0, '0, '0, '0, 4'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("refill_rsp1", {30'h0, rvalid, rdata}, {30'h0, 2'b10, 32'h0});
        step();
        read_all_zero("refill_word");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Round-robin arbiter and init sequencer placed in front of `sp_ram_wrap`. It shares the single-port RAM between `NUM_PORTS` requesters over a req/gnt/rvalid handshake. Its memory-side port drives the RAM wrapper directly. After reset it can optionally zero-fill the whole RAM before granting any requester, which gives a deterministic memory image on silicon targets.

## Interface
Parameters:
- `RAM_SIZE`, 32768: RAM size in bytes. `NUM_WORDS = RAM_SIZE/4`.
- `ADDR_WIDTH`, `$clog2(RAM_SIZE)`: byte-address width.
- `DATA_WIDTH`, 32: word width. Only 32 is supported.
- `NUM_PORTS`, 2: number of requesters, 2..8.
- `INIT_ZERO`, 1: 1 runs the zero-fill after reset. 0 skips it.

Ports (clock and reset first):
- Clock and reset:
  - `clk`  in  1  clock.
  - `rstn_i`  in  1  reset. One clock; reset is synchronous and active-low.
- Requester side:
  - `req_i`  in  NUM_PORTS  request per port.
  - `gnt_o`  out  NUM_PORTS  grant per port; one-hot or zero.
  - `addr_i`  in  NUM_PORTS*ADDR_WIDTH  byte address; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
  - `we_i`  in  NUM_PORTS  1 = write.
  - `be_i`  in  NUM_PORTS*4  byte enables.
  - `wdata_i`  in  NUM_PORTS*32  write data.
  - `rvalid_o`  out  NUM_PORTS  response valid per port.
  - `rdata_o`  out  32  shared read data; qualified by `rvalid_o`.
  - `init_done_o`  out  1  high once arbitration is enabled.
- Memory side:
  - `mem_en_o`  out  1  RAM enable.
  - `mem_addr_o`  out  ADDR_WIDTH  byte address; bits [1:0] always 0.
  - `mem_wdata_o`  out  32  write data.
  - `mem_we_o`  out  1  write enable.
  - `mem_be_o`  out  4  byte enables.
  - `mem_rdata_i`  in  32  RAM read data, valid one cycle after a read enable.

## Operation
- FSM states: INIT, ARB.
  - Reset enters INIT when `INIT_ZERO`=1, otherwise ARB.
  - INIT to ARB happens on the cycle after the last word is written.
- INIT:
  - A `$clog2(NUM_WORDS)`-bit counter `wcnt` starts at 0.
  - Each cycle: `mem_en_o`=1, `mem_we_o`=1, `mem_be_o`=4'hF, `mem_wdata_o`=0, `mem_addr_o`={wcnt,2'b00}.
  - `wcnt` increments; at `NUM_WORDS-1` the FSM moves to ARB.
  - `gnt_o`=0 and `init_done_o`=0 throughout. Requests are held off, not dropped.
- ARB:
  - `init_done_o`=1.
  - Round-robin pointer `rr` (0..NUM_PORTS-1). The grant goes to the first port with `req_i` set, scanning `rr`, `rr+1`, … modulo NUM_PORTS.
  - On a grant to port k, `rr` becomes (k+1) mod NUM_PORTS. With no grant, `rr` holds.
  - The granted port's addr/we/be/wdata are muxed to the memory outputs with `mem_en_o`=1 and `mem_addr_o`={addr[ADDR_WIDTH-1:2],2'b00}.
  - With no request: `mem_en_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Response:
  - A registered one-hot `resp_q` is loaded with `gnt_o` each cycle. `rvalid_o`=`resp_q`.
  - `rdata_o` = `mem_rdata_i` when any `resp_q` bit is set, else 0.
  - Writes also return `rvalid`; `rdata_o` is don't-care for writes.
- Requester rule: addr/we/be/wdata stay stable while `req_i` is high and `gnt_o` is low. The arbiter does not latch them.

## Timing
- Reset (while `rstn_i`=0 at a clock edge):
  - Outputs: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `init_done_o`=0, all `mem_*_o`=0.
  - State: `wcnt`=0, `rr`=0.
  - Outputs remain 0 for the whole reset-low period.
- Grant timing:
  - `gnt_o` is combinational from `req_i`, `rr` and state, in the same cycle as the request.
  - Latency: request at cycle t granted at t gives `rvalid_o` at t+1.
  - Throughput: one access per cycle, back-to-back across any ports.
- Init duration:
  - Zero-fill takes exactly `NUM_WORDS` cycles after reset release.
  - The first grant is possible in cycle `NUM_WORDS`, counting the first post-reset cycle as 0.
- Boundary cases:
  - Reset mid-INIT: the fill restarts at word 0.
  - Reset mid-access: the pending `rvalid` is dropped (0 after the reset edge).
  - Request during INIT: held until ARB, then served by round-robin.
  - Single requester at 100% load: granted every cycle.
  - All ports requesting: strict rotation; no port waits more than NUM_PORTS-1 cycles.
  - `rr` wraps from NUM_PORTS-1 to 0.

## Test plan
- Zero-fill: RAM_SIZE=64, INIT_ZERO=1.
  - Stimulus: release reset.
  - Required: 16 cycles of writes to addresses 0x00..0x3C with data 0; `init_done_o` rises in cycle 16; every word then reads 0.
- Single port:
  - Stimulus: write 0xDEADBEEF to 0x10 with be=F, then read 0x10.
  - Required: gnt in the same cycle; rvalid one cycle later; rdata=0xDEADBEEF.
- Byte enables:
  - Stimulus: write 0x000000AA be=0001 and 0x0000BB00 be=0010 to 0x20, then read 0x20.
  - Required: rdata=0x0000BBAA.
- Contention, NUM_PORTS=2:
  - Stimulus: both ports request continuously for 6 cycles.
  - Required: grants 0,1,0,1,0,1; each rvalid arrives one cycle after its grant with the correct port's data.
- Reset mid-INIT:
  - Stimulus: assert `rstn_i`=0 at wcnt=7 for 2 cycles.
  - Required: all outputs 0 during reset; the fill restarts at address 0 and completes 16 cycles after release.
- Reset mid-access and held request:
  - Stimulus: reset in the cycle after a grant.
  - Required: no rvalid is issued.
  - Stimulus: a request raised during INIT.
  - Required: served in the first ARB cycle.
